adc_spi_responder: RTL and testbench

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

---
 rtl/adc_spi_responder.sv | 165 ++++++++++++++++
 tb/tb_adc_spi_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// SPI slave that serializes the latest ADC sample as a fixed-length, MSB-first frame.
// SCLK and CS are synchronized into the clk domain; every output is registered.
module adc_spi_responder #(
  parameter int unsigned DATA_W      = 10,
  parameter int unsigned LEAD_BITS   = 3,
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              SPI_clk,
  input  logic              CS,
  input  logic [DATA_W-1:0] Sample_in,
  input  logic              Sample_valid,
  output logic              SPI_Data_out,
  output logic              Busy,
  output logic              Frame_done,
  output logic              Frame_abort,
  output logic              Stale
);

  localparam int unsigned TRAIL_BITS = FRAME_BITS - LEAD_BITS - DATA_W;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int unsigned SETTLE     = SYNC_STAGES + 1;
  localparam int unsigned SET_W      = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_last, cs_last;
  logic                   sclk_fall_q, cs_fall_q, cs_rise_q;
  logic [SET_W-1:0]       settle_cnt;
  logic                   armed;

  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [FRAME_BITS-1:0]  shreg, shreg_d;
  logic [DATA_W-1:0]      hold, hold_d;
  logic                   fresh, fresh_d;
  logic                   dout_q, dout_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   abort_q, abort_d;
  logic                   stale_q, stale_d;

  assign sclk_last = sclk_sync[SYNC_STAGES-1];
  assign cs_last   = cs_sync[SYNC_STAGES-1];

  // Synchronizers and registered edge strobes. The chains reset to the idle-high
  // level, so a CS held low through reset would look like a falling edge; a frame
  // may only start after CS has been seen high once the chain holds real pin values.
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      sclk_sync   <= '1;
      cs_sync     <= '1;
      sclk_prev   <= 1'b1;
      cs_prev     <= 1'b1;
      sclk_fall_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      settle_cnt  <= '0;
      armed       <= 1'b0;
    end else begin
      sclk_sync   <= SYNC_STAGES'({sclk_sync, SPI_clk});
      cs_sync     <= SYNC_STAGES'({cs_sync, CS});
      sclk_prev   <= sclk_last;
      cs_prev     <= cs_last;
      sclk_fall_q <= sclk_prev & ~sclk_last;
      cs_fall_q   <= cs_prev & ~cs_last;
      cs_rise_q   <= ~cs_prev & cs_last;
      if (settle_cnt != SET_W'(SETTLE)) settle_cnt <= settle_cnt + SET_W'(1);
      if ((settle_cnt == SET_W'(SETTLE)) && cs_last) armed <= 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      hold    <= '0;
      fresh   <= 1'b0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      shreg   <= shreg_d;
      hold    <= hold_d;
      fresh   <= fresh_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      stale_q <= stale_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    shreg_d = shreg;
    hold_d  = Sample_valid ? Sample_in : hold;
    fresh_d = fresh | Sample_valid;
    dout_d  = dout_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    stale_d = stale_q;

    case (state)
      IDLE: begin
        dout_d = 1'b0;
        if (cs_fall_q && armed) begin
          // hold_d already includes a same-cycle Sample_valid
          shreg_d = FRAME_BITS'(hold_d) << TRAIL_BITS;
          cnt_d   = '0;
          dout_d  = shreg_d[FRAME_BITS-1];
          stale_d = ~(fresh | Sample_valid);
          fresh_d = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise_q) begin
          abort_d = 1'b1;
          dout_d  = 1'b0;
          state_d = IDLE;
        end else if (sclk_fall_q && !cs_last) begin
          cnt_d = cnt + CNT_W'(1);
          if (cnt == CNT_W'(FRAME_BITS - 1)) begin
            done_d  = 1'b1;
            dout_d  = 1'b0;
            state_d = DONE;
          end else begin
            shreg_d = shreg << 1;
            dout_d  = shreg_d[FRAME_BITS-1];
          end
        end
      end
      DONE: begin
        dout_d = 1'b0;
        if (cs_rise_q) state_d = IDLE;
      end
      default: begin
        dout_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
  end

  assign SPI_Data_out = dout_q;
  assign Busy         = busy_q;
  assign Frame_done   = done_q;
  assign Frame_abort  = abort_q;
  assign Stale        = stale_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: an SPI master model drives frames and a
// queue of expected MISO bits is popped at every SCLK rising edge.
module tb_adc_spi_responder;

  localparam int DW = 10;
  localparam int LB = 3;
  localparam int FB = 16;

  logic          clk = 1'b0;
  logic          reset_b;
  logic          SPI_clk;
  logic          CS;
  logic [DW-1:0] Sample_in;
  logic          Sample_valid;
  logic          SPI_Data_out;
  logic          Busy;
  logic          Frame_done;
  logic          Frame_abort;
  logic          Stale;

  int   compared   = 0;
  int   mismatched = 0;
  int   done_cnt   = 0;
  int   abort_cnt  = 0;
  int   d0, a0;
  logic exp_q[$];

  adc_spi_responder #(
    .DATA_W(DW), .LEAD_BITS(LB), .FRAME_BITS(FB), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset_b(reset_b), .SPI_clk(SPI_clk), .CS(CS),
    .Sample_in(Sample_in), .Sample_valid(Sample_valid),
    .SPI_Data_out(SPI_Data_out), .Busy(Busy), .Frame_done(Frame_done),
    .Frame_abort(Frame_abort), .Stale(Stale)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (Frame_done)  done_cnt++;
    if (Frame_abort) abort_cnt++;
  end

  function automatic logic frame_bit(input logic [DW-1:0] d, input int k);
    if (k < LB) return 1'b0;
    if (k < LB + DW) return d[DW-1-(k-LB)];
    return 1'b0;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [DW-1:0] d);
    @(negedge clk);
    Sample_in    = d;
    Sample_valid = 1'b1;
    @(negedge clk);
    Sample_valid = 1'b0;
  endtask

  // Queue the bits the master will see at its next nbits rising edges, then drop CS
  task automatic cs_low(input logic [DW-1:0] d, input int nbits);
    for (int k = 0; k < nbits; k++) exp_q.push_back(frame_bit(d, k));
    d0 = done_cnt;
    a0 = abort_cnt;
    CS = 1'b0;
    clocks(8);
  endtask

  task automatic cs_high();
    CS = 1'b1;
    clocks(8);
  endtask

  // Each cycle: sample MISO and raise SCLK, then drop SCLK (the responder shifts on the fall)
  task automatic sclk(input int n);
    logic e;
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
      check_bit("miso", SPI_Data_out, e);
      SPI_clk = 1'b1;
      clocks(6);
      SPI_clk = 1'b0;
      clocks(6);
    end
  endtask

  task automatic frame_end(input string tag, input logic stale_exp);
    check_int({tag, "_done_pulses"}, done_cnt - d0, 1);
    check_int({tag, "_abort_pulses"}, abort_cnt - a0, 0);
    check_bit({tag, "_stale"}, Stale, stale_exp);
    check_bit({tag, "_busy"}, Busy, 1'b0);
    check_bit({tag, "_miso_idle"}, SPI_Data_out, 1'b0);
  endtask

  initial begin
    reset_b      = 1'b1;
    SPI_clk      = 1'b0;
    CS           = 1'b1;
    Sample_in    = '0;
    Sample_valid = 1'b0;
    clocks(4);
    check_bit("rst_miso", SPI_Data_out, 1'b0);
    check_bit("rst_busy", Busy, 1'b0);
    check_bit("rst_done", Frame_done, 1'b0);
    check_bit("rst_abort", Frame_abort, 1'b0);
    check_bit("rst_stale", Stale, 1'b0);
    reset_b = 1'b0;
    clocks(6);

    // Basic frame of 0x2B5
    load(10'h2B5);
    cs_low(10'h2B5, FB);
    check_bit("f1_busy", Busy, 1'b1);
    sclk(FB);
    frame_end("f1", 1'b0);
    cs_high();

    // No new sample: resend, flagged stale
    cs_low(10'h2B5, FB);
    sclk(FB);
    frame_end("f2", 1'b1);
    cs_high();

    // Abort after 7 falling edges
    load(10'h155);
    cs_low(10'h155, 7);
    sclk(7);
    CS = 1'b1;
    clocks(8);
    check_int("ab_abort_pulses", abort_cnt - a0, 1);
    check_int("ab_done_pulses", done_cnt - d0, 0);
    check_bit("ab_busy", Busy, 1'b0);
    check_bit("ab_miso", SPI_Data_out, 1'b0);
    load(10'h0F0);
    cs_low(10'h0F0, FB);
    sclk(FB);
    frame_end("after_ab", 1'b0);
    cs_high();

    // New sample mid-frame lands in the next frame only
    load(10'h001);
    cs_low(10'h001, FB);
    sclk(5);
    load(10'h3FF);
    sclk(FB - 5);
    frame_end("cur001", 1'b0);
    cs_high();
    cs_low(10'h3FF, FB);
    sclk(FB);
    frame_end("next3ff", 1'b0);
    cs_high();

    // Extra SCLK cycles past the frame keep MISO low
    cs_low(10'h3FF, FB + 4);
    sclk(FB + 4);
    frame_end("extra", 1'b1);
    cs_high();

    // Sample_valid together with CS falling
    @(negedge clk);
    for (int k = 0; k < FB; k++) exp_q.push_back(frame_bit(10'h0AA, k));
    d0           = done_cnt;
    a0           = abort_cnt;
    Sample_in    = 10'h0AA;
    Sample_valid = 1'b1;
    CS           = 1'b0;
    @(negedge clk);
    Sample_valid = 1'b0;
    clocks(7);
    sclk(FB);
    frame_end("same_cyc", 1'b0);
    cs_high();

    // Reset mid-frame, then CS stays low after release
    load(10'h2B5);
    cs_low(10'h2B5, FB);
    sclk(5);
    check_bit("pre_rst_miso", SPI_Data_out, 1'b1);
    reset_b = 1'b1;
    #1;
    check_bit("mid_rst_miso", SPI_Data_out, 1'b0);
    check_bit("mid_rst_busy", Busy, 1'b0);
    check_bit("mid_rst_stale", Stale, 1'b0);
    clocks(3);
    reset_b = 1'b0;
    exp_q.delete();
    clocks(4);
    check_int("mid_rst_done_pulses", done_cnt - d0, 0);
    check_int("mid_rst_abort_pulses", abort_cnt - a0, 0);
    sclk(4);
    check_bit("post_rst_busy", Busy, 1'b0);
    cs_high();
    load(10'h1C3);
    cs_low(10'h1C3, FB);
    sclk(FB);
    frame_end("post_rst", 1'b0);
    cs_high();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
